fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Front-end fetch stage that owns the fetch PC, issues 4-wide reads to the synchronous instruction memory and presents one bundle per cycle (pc + four 16-bit instructions) to the jump handler directly downstream. It applies redirects from branch mispredict and from the jump handler, and absorbs back-pressure from the instruction queue with a one-entry skid buffer so that no fetched bundle is lost or duplicated.

## Interface
- RESET_PC, 16'h0000, fetch PC loaded at reset
- clk  in  1  clock; reset rst_n, asynchronous, active-low
- rst_n  in  1  asynchronous active-low reset
- has_mispredict  in  1  flush front end, redirect to mispredict_pc
- mispredict_pc  in  16  correct-path PC
- jump_for_pcsel  in  1  jump handler redirect request
- jump_addr_pc  in  16  jump handler redirect target
- stall_from_iq  in  1  downstream cannot accept the current bundle
- imem_rd_en  out  1  read strobe
- imem_addr  out  16  word address of instruction0
- imem_data  in  64  read data, one cycle after strobe; [15:0]=addr, [31:16]=addr+1, [47:32]=addr+2, [63:48]=addr+3
- pc  out  16  word address of instruction0 of the current bundle
- instruction0..instruction3  out  16 each  current bundle; 16'h0000 = nop
- bundle_valid  out  1  current bundle is real (not a bubble)

## Operation
- State: fetch_pc, req_pc/req_vld (read issued last cycle), skid_pc/skid_ins/skid_vld.
- Output select: skid_vld -> skid contents, valid=1; else req_vld -> req_pc + imem_data, valid=1; else pc=req_pc, all instructions 0, valid=0.
- Bundle accepted = bundle_valid && !stall_from_iq.
- Per-cycle priority:
  - has_mispredict: imem_rd_en=0; skid_vld<=0, req_vld<=0; fetch_pc<=mispredict_pc. Honoured regardless of stall.
  - else stall_from_iq: imem_rd_en=0; fetch_pc held; if req_vld && !skid_vld, capture response into skid; req_vld<=0; jump_for_pcsel ignored.
  - else jump_for_pcsel: imem_rd_en=0; fetch_pc<=jump_addr_pc; req_vld<=0; skid_vld<=0.
  - else: imem_rd_en=1, imem_addr=fetch_pc; req_pc<=fetch_pc; req_vld<=1; fetch_pc<=fetch_pc+4; skid_vld<=0.
- imem_addr = fetch_pc at all times; it is meaningful only when imem_rd_en=1.
- Arithmetic is 16-bit modulo; fetch_pc+4 wraps (16'hFFFC -> 16'h0000). No alignment constraint; imem serves unaligned 4-word reads.
- A stall while skid_vld holds the skid unchanged. skid_vld and req_vld are never both 1.

## Timing
- Reset values: fetch_pc=RESET_PC, req_pc=RESET_PC, req_vld=0, skid_vld=0. Hence pc=RESET_PC, instructions=0, bundle_valid=0, imem_rd_en=0 while rst_n=0.
- First read is issued on the first clk edge after reset release. That bundle appears one cycle later.
- Steady state: one bundle per cycle, read-to-output latency 1 cycle.
- Jump redirect penalty: exactly one bubble cycle (valid=0). The bundle at jump_addr_pc appears 2 cycles after the redirect cycle.
- Mispredict penalty: one bubble cycle. The bundle at mispredict_pc is output 2 cycles after the has_mispredict cycle.
- Stall release: the held bundle (skid) is output in the first unstalled cycle. The next read is issued in that same cycle, so output stays back-to-back with no gap.
- Mispredict asserted mid-stall or mid-redirect overrides both. Reset mid-operation returns all state to reset values asynchronously.

## Configuration
- FETCH_REDIRECT_BYPASS_EN defined:
  - On an unstalled jump_for_pcsel (no mispredict), drive imem_rd_en=1 and imem_addr=jump_addr_pc combinationally.
  - Update req_pc<=jump_addr_pc, req_vld<=1, fetch_pc<=jump_addr_pc+4.
  - Result: zero-bubble jump redirect; the target bundle appears 1 cycle after the redirect cycle.
- Undefined: registered redirect as in Operation, with a one-bubble penalty.
- Mispredict behaviour is identical in both builds.

## Test plan
- Reset, RESET_PC=0, imem returns data = address: imem_rd_en=1 in cycle 1. From cycle 2, bundles pc=0x0000, 0x0004, 0x0008 back-to-back, each with instruction0=pc and bundle_valid=1.
- jump_for_pcsel=1, jump_addr_pc=0x0040 in the cycle pc=0x0008 is output: next cycle bundle_valid=0, instructions=0. Following cycle pc=0x0040, valid=1. With FETCH_REDIRECT_BYPASS_EN, pc=0x0040 appears in the next cycle.
- stall_from_iq=1 for 3 cycles while pc=0x0010 is output: pc=0x0010 is held for all 3 cycles with imem_rd_en=0. After release, the sequence is 0x0010 then 0x0014, with no loss or duplicate.
- has_mispredict=1, mispredict_pc=0x0100 while stalled with skid full: skid is dropped. Next cycle bundle_valid=0; the cycle after, pc=0x0100.
- RESET_PC=16'hFFFC: bundles pc=0xFFFC then 0x0000.
- rst_n pulsed low mid-stream: outputs immediately return to pc=RESET_PC, bundle_valid=0, imem_rd_en=0.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: owns the fetch PC, issues 4-wide imem reads and presents one bundle per cycle.
// Define FETCH_REDIRECT_BYPASS_EN for a zero-bubble jump redirect (imem read issued in the jump cycle).
module fetch_pc_gen #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        has_mispredict,
    input  logic [15:0] mispredict_pc,
    input  logic        jump_for_pcsel,
    input  logic [15:0] jump_addr_pc,
    input  logic        stall_from_iq,
    output logic        imem_rd_en,
    output logic [15:0] imem_addr,
    input  logic [63:0] imem_data,
    output logic [15:0] pc,
    output logic [15:0] instruction0,
    output logic [15:0] instruction1,
    output logic [15:0] instruction2,
    output logic [15:0] instruction3,
    output logic        bundle_valid
);

    logic [15:0] fetch_pc, fetch_pc_d;
    logic [15:0] req_pc, req_pc_d;
    logic        req_vld, req_vld_d;
    logic [15:0] skid_pc, skid_pc_d;
    logic [63:0] skid_ins, skid_ins_d;
    logic        skid_vld, skid_vld_d;
    logic        rd_en_c;
    logic [63:0] bundle;

    // A held (skid) bundle always takes precedence over the response of the read issued last cycle.
    always_comb begin
        bundle       = 64'h0;
        pc           = req_pc;
        bundle_valid = 1'b0;
        if (skid_vld) begin
            bundle       = skid_ins;
            pc           = skid_pc;
            bundle_valid = 1'b1;
        end else if (req_vld) begin
            bundle       = imem_data;
            bundle_valid = 1'b1;
        end
    end

    assign instruction0 = bundle[15:0];
    assign instruction1 = bundle[31:16];
    assign instruction2 = bundle[47:32];
    assign instruction3 = bundle[63:48];

    always_comb begin
        rd_en_c    = 1'b0;
        imem_addr  = fetch_pc;
        fetch_pc_d = fetch_pc;
        req_pc_d   = req_pc;
        req_vld_d  = req_vld;
        skid_pc_d  = skid_pc;
        skid_ins_d = skid_ins;
        skid_vld_d = skid_vld;
        if (has_mispredict) begin
            fetch_pc_d = mispredict_pc;
            req_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (stall_from_iq) begin
            // Park the in-flight response; an already full skid is left untouched.
            if (req_vld && !skid_vld) begin
                skid_pc_d  = req_pc;
                skid_ins_d = imem_data;
                skid_vld_d = 1'b1;
            end
            req_vld_d = 1'b0;
        end else if (jump_for_pcsel) begin
`ifdef FETCH_REDIRECT_BYPASS_EN
            rd_en_c    = 1'b1;
            imem_addr  = jump_addr_pc;
            req_pc_d   = jump_addr_pc;
            req_vld_d  = 1'b1;
            fetch_pc_d = jump_addr_pc + 16'd4;
            skid_vld_d = 1'b0;
`else
            fetch_pc_d = jump_addr_pc;
            req_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
`endif
        end else begin
            rd_en_c    = 1'b1;
            req_pc_d   = fetch_pc;
            req_vld_d  = 1'b1;
            fetch_pc_d = fetch_pc + 16'd4;
            skid_vld_d = 1'b0;
        end
    end

    // Strobe is masked while in reset so no read escapes before the first post-reset edge.
    assign imem_rd_en = rd_en_c & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            req_vld  <= 1'b0;
            skid_pc  <= RESET_PC;
            skid_ins <= 64'h0;
            skid_vld <= 1'b0;
        end else begin
            fetch_pc <= fetch_pc_d;
            req_pc   <= req_pc_d;
            req_vld  <= req_vld_d;
            skid_pc  <= skid_pc_d;
            skid_ins <= skid_ins_d;
            skid_vld <= skid_vld_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed and random redirect/stall traffic checked against a bundle-stream model.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        has_mispredict;
    logic [15:0] mispredict_pc;
    logic        jump_for_pcsel;
    logic [15:0] jump_addr_pc;
    logic        stall_from_iq;

    logic        imem_rd_en, imem_rd_en_w;
    logic [15:0] imem_addr, imem_addr_w;
    logic [63:0] imem_data, imem_data_w;
    logic [15:0] pc, pc_w;
    logic [15:0] ins0, ins1, ins2, ins3;
    logic [15:0] ins0_w, ins1_w, ins2_w, ins3_w;
    logic        bundle_valid, bundle_valid_w;

    int checks = 0;
    int errors = 0;

    // Model: what is shown this cycle, the next address to fetch, and the last address read.
    logic        m_valid;
    logic [15:0] m_pc;
    logic [15:0] m_fetch;
    logic [15:0] m_last;

    always #5 clk = ~clk;

    fetch_pc_gen #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .has_mispredict(has_mispredict), .mispredict_pc(mispredict_pc),
        .jump_for_pcsel(jump_for_pcsel), .jump_addr_pc(jump_addr_pc),
        .stall_from_iq(stall_from_iq),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .pc(pc), .instruction0(ins0), .instruction1(ins1),
        .instruction2(ins2), .instruction3(ins3), .bundle_valid(bundle_valid)
    );

    fetch_pc_gen #(.RESET_PC(16'hFFFC)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .has_mispredict(has_mispredict), .mispredict_pc(mispredict_pc),
        .jump_for_pcsel(jump_for_pcsel), .jump_addr_pc(jump_addr_pc),
        .stall_from_iq(stall_from_iq),
        .imem_rd_en(imem_rd_en_w), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
        .pc(pc_w), .instruction0(ins0_w), .instruction1(ins1_w),
        .instruction2(ins2_w), .instruction3(ins3_w), .bundle_valid(bundle_valid_w)
    );

    function automatic logic [63:0] words(input logic [15:0] a);
        return {a + 16'd3, a + 16'd2, a + 16'd1, a};
    endfunction

    // Word at address a holds a; idle cycles return garbage so stale data is exposed.
    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= words(imem_addr);
        else            imem_data <= {$urandom, $urandom};
        if (imem_rd_en_w) imem_data_w <= words(imem_addr_w);
        else              imem_data_w <= {$urandom, $urandom};
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_valid = 1'b0;
        m_pc    = 16'h0000;
        m_fetch = 16'h0000;
        m_last  = 16'h0000;
    endtask

    // Called just after a falling edge: drive, check the cycle, advance the model, wait one cycle.
    task automatic applyStimulus(input logic mp, input logic [15:0] mpc, input logic jmp,
                                 input logic [15:0] jaddr, input logic stall);
        logic        exp_rd;
        logic [15:0] exp_addr;
        logic        bypass;
`ifdef FETCH_REDIRECT_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        has_mispredict = mp;
        mispredict_pc  = mpc;
        jump_for_pcsel = jmp;
        jump_addr_pc   = jaddr;
        stall_from_iq  = stall;
        #1;
        exp_rd   = !mp && !stall && (!jmp || bypass);
        exp_addr = jmp ? jaddr : m_fetch;
        checkOutput("imem_rd_en", {63'h0, imem_rd_en}, {63'h0, exp_rd});
        if (exp_rd) checkOutput("imem_addr", {48'h0, imem_addr}, {48'h0, exp_addr});
        checkOutput("bundle_valid", {63'h0, bundle_valid}, {63'h0, m_valid});
        checkOutput("pc", {48'h0, pc}, {48'h0, m_pc});
        checkOutput("instructions", {ins3, ins2, ins1, ins0}, m_valid ? words(m_pc) : 64'h0);
        if (mp) begin
            m_valid = 1'b0;
            m_pc    = m_last;
            m_fetch = mpc;
        end else if (stall) begin
            m_valid = m_valid;
        end else if (jmp && !bypass) begin
            m_valid = 1'b0;
            m_pc    = m_last;
            m_fetch = jaddr;
        end else begin
            m_valid = 1'b1;
            m_pc    = exp_addr;
            m_last  = exp_addr;
            m_fetch = exp_addr + 16'd4;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        has_mispredict = 1'b0; mispredict_pc = 16'h0;
        jump_for_pcsel = 1'b0; jump_addr_pc = 16'h0;
        stall_from_iq = 1'b0;
        modelReset();
        @(negedge clk);
        #1;
        checkOutput("reset_pc", {48'h0, pc}, 64'h0);
        checkOutput("reset_valid", {63'h0, bundle_valid}, 64'h0);
        checkOutput("reset_rd_en", {63'h0, imem_rd_en}, 64'h0);
        checkOutput("reset_ins", {ins3, ins2, ins1, ins0}, 64'h0);
        checkOutput("reset_pc_w", {48'h0, pc_w}, 64'hFFFC);
        checkOutput("reset_rd_en_w", {63'h0, imem_rd_en_w}, 64'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("first_rd_en_w", {63'h0, imem_rd_en_w}, 64'h1);
        checkOutput("first_addr_w", {48'h0, imem_addr_w}, 64'hFFFC);

        applyStimulus(0, 16'h0, 0, 16'h0, 0);
        #1;
        checkOutput("wrap_pc0_w", {48'h0, pc_w}, 64'hFFFC);
        checkOutput("wrap_valid0_w", {63'h0, bundle_valid_w}, 64'h1);
        checkOutput("wrap_ins0_w", {ins3_w, ins2_w, ins1_w, ins0_w}, 64'hFFFF_FFFE_FFFD_FFFC);
        applyStimulus(0, 16'h0, 0, 16'h0, 0);
        #1;
        checkOutput("wrap_pc1_w", {48'h0, pc_w}, 64'h0000);
        checkOutput("wrap_ins1_w", {ins3_w, ins2_w, ins1_w, ins0_w}, 64'h0003_0002_0001_0000);

        // Shows pc 4 then pc 8 with a jump to 0x40.
        applyStimulus(0, 16'h0, 0, 16'h0, 0);
        applyStimulus(0, 16'h0, 1, 16'h0040, 0);
        applyStimulus(0, 16'h0, 0, 16'h0, 0);
        applyStimulus(0, 16'h0, 0, 16'h0, 0);
        applyStimulus(0, 16'h0, 0, 16'h0, 0);
        // Stall three cycles, release, then mispredict while the skid is full.
        for (int i = 0; i < 3; i++) applyStimulus(0, 16'h0, 1, 16'h1234, 1);
        applyStimulus(0, 16'h0, 0, 16'h0, 0);
        applyStimulus(0, 16'h0, 0, 16'h0, 0);
        applyStimulus(0, 16'h0, 0, 16'h0, 1);
        applyStimulus(0, 16'h0, 0, 16'h0, 1);
        applyStimulus(1, 16'h0100, 1, 16'h0200, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 16'h0, 0, 16'h0, 0);
        // Redirect into the wrap region.
        applyStimulus(0, 16'h0, 1, 16'hFFFA, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 16'h0, 0, 16'h0, 0);

        for (int i = 0; i < 400; i++) begin
            logic        mp, jmp, stall;
            logic [15:0] mpc, jaddr;
            mp    = ($urandom_range(0, 19) == 0);
            jmp   = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            mpc   = 16'($urandom);
            jaddr = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
            applyStimulus(mp, mpc, jmp, jaddr, stall);
        end

        // Asynchronous reset mid-stream.
        applyStimulus(0, 16'h0, 0, 16'h0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_pc", {48'h0, pc}, 64'h0);
        checkOutput("midreset_valid", {63'h0, bundle_valid}, 64'h0);
        checkOutput("midreset_rd_en", {63'h0, imem_rd_en}, 64'h0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(0, 16'h0, 0, 16'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
